sdr_wb_arbiter: RTL and testbench

- Two-master round-robin Wishbone arbiter that shares the single Wishbone slave port of the SDRAM controller (sdrc_top) between two requesters, e.g. a CPU port and a DMA port.
- Holds each grant for the whole cycle (cyc high), including incrementing bursts (cti), so SDRAM bursts are never interleaved.
- Blocks all grants until sdr_init_done.
- Includes an ack watchdog so a hung transfer cannot lock the controller.

---
 rtl/sdr_wb_arbiter.sv | 157 +++++++++++++++
 tb/tb_sdr_wb_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdr_wb_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the SDRAM controller slave port.
// Grants are held for a whole cycle; an ack watchdog aborts transfers that never complete.
module sdr_wb_arbiter #(
  parameter int APP_AW  = 26,
  parameter int APP_DW  = 32,
  parameter int APP_BW  = 4,
  parameter int TMO_CYC = 255
) (
  input  logic              sys_clk,
  input  logic              resetn,
  input  logic              sdr_init_done,

  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  input  logic              m0_we_i,
  input  logic [APP_AW-1:0] m0_addr_i,
  input  logic [APP_BW-1:0] m0_sel_i,
  input  logic [APP_DW-1:0] m0_dat_i,
  input  logic [2:0]        m0_cti_i,
  output logic [APP_DW-1:0] m0_dat_o,
  output logic              m0_ack_o,
  output logic              m0_err_o,

  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  input  logic              m1_we_i,
  input  logic [APP_AW-1:0] m1_addr_i,
  input  logic [APP_BW-1:0] m1_sel_i,
  input  logic [APP_DW-1:0] m1_dat_i,
  input  logic [2:0]        m1_cti_i,
  output logic [APP_DW-1:0] m1_dat_o,
  output logic              m1_ack_o,
  output logic              m1_err_o,

  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic              s_we_o,
  output logic [APP_AW-1:0] s_addr_o,
  output logic [APP_BW-1:0] s_sel_o,
  output logic [APP_DW-1:0] s_dat_o,
  output logic [2:0]        s_cti_o,
  input  logic [APP_DW-1:0] s_dat_i,
  input  logic              s_ack_i,

  output logic [1:0]        grant,
  output logic              tmo_flag
);

  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

  localparam logic [15:0] TMO_LIM = 16'(TMO_CYC);

  state_t      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        last_q, last_d;
  logic        tmo_flag_q, tmo_flag_d;
  logic [15:0] cnt_q, cnt_d;

  logic        busy;
  logic        own_sel;
  logic        own_cyc;
  logic        own_stb;
  logic        expire;
  logic        win;

  assign busy    = (state_q == BUSY);
  assign own_sel = grant_q[1];
  assign own_cyc = own_sel ? m1_cyc_i : m0_cyc_i;
  assign own_stb = own_sel ? m1_stb_i : m0_stb_i;
  // A cycle drop takes priority over expiry, so expiry requires the owner to still hold cyc.
  assign expire  = busy && own_cyc && (cnt_q == TMO_LIM);

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    tmo_flag_d = tmo_flag_q;
    cnt_d      = cnt_q;
    win        = 1'b0;
    case (state_q)
      IDLE: begin
        if (sdr_init_done && (m0_cyc_i || m1_cyc_i)) begin
          win     = (m0_cyc_i && m1_cyc_i) ? ~last_q : m1_cyc_i;
          grant_d = win ? 2'b10 : 2'b01;
          last_d  = win;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!own_cyc || expire) begin
          state_d = GAP;
          grant_d = '0;
          cnt_d   = '0;
          if (expire) tmo_flag_d = 1'b1;
        end else if (own_stb && !s_ack_i) begin
          cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 16'd1;
        end else begin
          cnt_d = '0;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      last_q     <= 1'b1;
      tmo_flag_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      tmo_flag_q <= tmo_flag_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_addr_o = '0;
    s_sel_o  = '0;
    s_dat_o  = '0;
    s_cti_o  = '0;
    m0_ack_o = 1'b0;
    m1_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_err_o = 1'b0;
    m0_dat_o = '0;
    m1_dat_o = '0;
    if (busy) begin
      s_cyc_o  = own_cyc && !expire;
      s_stb_o  = own_stb && !expire;
      s_we_o   = own_sel ? m1_we_i   : m0_we_i;
      s_addr_o = own_sel ? m1_addr_i : m0_addr_i;
      s_sel_o  = own_sel ? m1_sel_i  : m0_sel_i;
      s_dat_o  = own_sel ? m1_dat_i  : m0_dat_i;
      s_cti_o  = own_sel ? m1_cti_i  : m0_cti_i;
      m0_ack_o = !own_sel && own_cyc && s_ack_i && !expire;
      m1_ack_o =  own_sel && own_cyc && s_ack_i && !expire;
      m0_err_o = !own_sel && expire;
      m1_err_o =  own_sel && expire;
      m0_dat_o = s_dat_i;
      m1_dat_o = s_dat_i;
    end
  end

  assign grant    = grant_q;
  assign tmo_flag = tmo_flag_q;

endmodule

// File: tb/tb_sdr_wb_arbiter.sv
// Self-checking bench for sdr_wb_arbiter: directed scenarios plus randomized traffic
// compared each cycle against a behavioural owner/gap/watchdog model.
module tb_sdr_wb_arbiter;

  localparam int AW  = 26;
  localparam int DW  = 32;
  localparam int BW  = 4;
  localparam int TMO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          resetn;
  logic          init;
  logic [1:0]    cyc, stb, we;
  logic [AW-1:0] addr [2];
  logic [BW-1:0] sel  [2];
  logic [DW-1:0] wdat [2];
  logic [2:0]    cti  [2];
  logic [DW-1:0] s_dat_i;
  logic          s_ack_i;

  logic [DW-1:0] m0_dat_o, m1_dat_o;
  logic          m0_ack_o, m1_ack_o, m0_err_o, m1_err_o;
  logic          s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0] s_addr_o;
  logic [BW-1:0] s_sel_o;
  logic [DW-1:0] s_dat_o;
  logic [2:0]    s_cti_o;
  logic [1:0]    grant;
  logic          tmo_flag;

  int checks = 0;
  int errors = 0;

  sdr_wb_arbiter #(.APP_AW(AW), .APP_DW(DW), .APP_BW(BW), .TMO_CYC(TMO)) dut (
    .sys_clk(clk), .resetn(resetn), .sdr_init_done(init),
    .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_we_i(we[0]), .m0_addr_i(addr[0]),
    .m0_sel_i(sel[0]), .m0_dat_i(wdat[0]), .m0_cti_i(cti[0]),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_we_i(we[1]), .m1_addr_i(addr[1]),
    .m1_sel_i(sel[1]), .m1_dat_i(wdat[1]), .m1_cti_i(cti[1]),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o),
    .s_sel_o(s_sel_o), .s_dat_o(s_dat_o), .s_cti_o(s_cti_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .grant(grant), .tmo_flag(tmo_flag)
  );

  // Reference model: who owns the bus, whether a gap cycle is pending, the last winner,
  // the number of consecutive unanswered strobe cycles and the sticky timeout flag.
  int mo_owner = -1;
  bit mo_gap   = 1'b0;
  int mo_last  = 1;
  int mo_wait  = 0;
  bit mo_flag  = 1'b0;

  function automatic logic [138:0] exp_vec();
    bit busy, expired;
    int o;
    logic [1:0] g;
    logic sc, ss, swe, a0, a1, e0, e1;
    logic [AW-1:0] sa; logic [BW-1:0] sb; logic [DW-1:0] sd, rd; logic [2:0] sct;
    busy    = (mo_owner >= 0);
    o       = busy ? mo_owner : 0;
    expired = busy && cyc[o] && (mo_wait == TMO);
    g   = !busy ? 2'b00 : (o == 1 ? 2'b10 : 2'b01);
    sc  = busy && cyc[o] && !expired;
    ss  = busy && stb[o] && !expired;
    swe = busy ? we[o]   : 1'b0;
    sa  = busy ? addr[o] : '0;
    sb  = busy ? sel[o]  : '0;
    sd  = busy ? wdat[o] : '0;
    sct = busy ? cti[o]  : '0;
    a0  = busy && o == 0 && cyc[0] && s_ack_i && !expired;
    a1  = busy && o == 1 && cyc[1] && s_ack_i && !expired;
    e0  = expired && o == 0;
    e1  = expired && o == 1;
    rd  = busy ? s_dat_i : '0;
    return {g, mo_flag, sc, ss, swe, sa, sb, sd, sct, rd, a0, e0, rd, a1, e1};
  endfunction

  function automatic logic [138:0] act_vec();
    return {grant, tmo_flag, s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_sel_o, s_dat_o, s_cti_o,
            m0_dat_o, m0_ack_o, m0_err_o, m1_dat_o, m1_ack_o, m1_err_o};
  endfunction

  task automatic model_step();
    bit expired;
    if (!resetn) begin
      mo_owner = -1; mo_gap = 1'b0; mo_last = 1; mo_wait = 0; mo_flag = 1'b0;
    end else if (mo_owner >= 0) begin
      expired = cyc[mo_owner] && (mo_wait == TMO);
      if (!cyc[mo_owner] || expired) begin
        mo_flag  = mo_flag | expired;
        mo_owner = -1;
        mo_gap   = 1'b1;
      end else if (stb[mo_owner] && !s_ack_i) begin
        if (mo_wait < 65535) mo_wait = mo_wait + 1;
      end else begin
        mo_wait = 0;
      end
    end else if (mo_gap) begin
      mo_gap = 1'b0;
    end else if (init && cyc != 2'b00) begin
      mo_owner = (cyc == 2'b11) ? 1 - mo_last : (cyc[1] ? 1 : 0);
      mo_last  = mo_owner;
      mo_wait  = 0;
    end
  endtask

  // Advance one clock: update the model with the inputs seen at the edge, then step off it.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    cyc = '0; stb = '0; we = '0; s_ack_i = 1'b0; s_dat_i = $urandom;
    for (int unsigned i = 0; i < 2; i++) begin
      addr[i] = AW'($urandom); sel[i] = BW'($urandom); wdat[i] = $urandom; cti[i] = '0;
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0; init = 1'b0; idle_inputs();
    tick(); tick();
    resetn = 1'b1; init = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; init = 1'b0; idle_inputs();
    cyc[0] = 1'b1; s_dat_i = 32'hA5A5_5A5A;
    tick(); tick();
    #4;
    checks++; if (act_vec() !== exp_vec()) begin errors++; $display("FAIL reset_state got %h exp %h", act_vec(), exp_vec()); end
    checks++; if (grant !== 2'b00 || tmo_flag !== 1'b0 || m0_dat_o !== '0) begin errors++; $display("FAIL reset_outputs got grant=%b flag=%b dat=%h exp 00 0 0", grant, tmo_flag, m0_dat_o); end
    tick();
    resetn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #4;
      checks++; if (grant !== 2'b00 || s_cyc_o !== 1'b0) begin errors++; $display("FAIL no_init_grant got grant=%b s_cyc=%b exp 00 0", grant, s_cyc_o); end
      tick();
    end
    init = 1'b1;
    #4;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL init_same_cycle got %b exp 00", grant); end
    tick();
    #4;
    checks++; if (grant !== 2'b01 || s_cyc_o !== 1'b1) begin errors++; $display("FAIL init_grant got grant=%b s_cyc=%b exp 01 1", grant, s_cyc_o); end
    checks++; if (act_vec() !== exp_vec()) begin errors++; $display("FAIL init_vec got %h exp %h", act_vec(), exp_vec()); end
    tick();
  endtask

  task automatic test_single_write();
    stb[0] = 1'b1; we[0] = 1'b1; addr[0] = 26'h000_0040; wdat[0] = 32'hDEAD_BEEF; sel[0] = 4'hF;
    for (int k = 1; k <= 7; k++) begin
      s_ack_i = (k == 7);
      #4;
      checks++; if (s_addr_o !== 26'h000_0040 || s_dat_o !== 32'hDEAD_BEEF || s_we_o !== 1'b1) begin errors++; $display("FAIL wr_fields got addr=%h dat=%h we=%b", s_addr_o, s_dat_o, s_we_o); end
      checks++; if (m0_ack_o !== (k == 7) || m1_ack_o !== 1'b0) begin errors++; $display("FAIL wr_ack beat %0d got m0=%b m1=%b exp m0=%b m1=0", k, m0_ack_o, m1_ack_o, (k == 7)); end
      tick();
    end
    cyc[0] = 1'b0; stb[0] = 1'b0; s_ack_i = 1'b0;
    for (int d = 0; d < 3; d++) begin
      #4;
      checks++; if (s_cyc_o !== 1'b0 || m0_ack_o !== 1'b0 || grant !== (d == 0 ? 2'b01 : 2'b00)) begin errors++; $display("FAIL wr_release d=%0d got s_cyc=%b ack=%b grant=%b", d, s_cyc_o, m0_ack_o, grant); end
      checks++; if (act_vec() !== exp_vec()) begin errors++; $display("FAIL wr_release_vec got %h exp %h", act_vec(), exp_vec()); end
      tick();
    end
  endtask

  task automatic test_round_robin();
    int w;
    bit got;
    do_reset();
    cyc = 2'b11;
    for (int r = 0; r < 4; r++) begin
      got = 1'b0;
      for (int t = 0; t < 10 && !got; t++) begin
        #4;
        if (grant !== 2'b00) got = 1'b1; else tick();
      end
      checks++; if (!got) begin errors++; $display("FAIL rr_timeout round %0d got no grant exp grant", r); end
      w = r % 2;
      checks++; if (grant !== (w == 1 ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rr_order round %0d got %b exp %b", r, grant, (w == 1 ? 2'b10 : 2'b01)); end
      tick();
      stb[w] = 1'b1; s_ack_i = 1'b1;
      #4;
      checks++; if ((w == 0 ? m0_ack_o : m1_ack_o) !== 1'b1 || (w == 0 ? m1_ack_o : m0_ack_o) !== 1'b0) begin errors++; $display("FAIL rr_ack round %0d got m0=%b m1=%b", r, m0_ack_o, m1_ack_o); end
      tick();
      cyc[w] = 1'b0; stb[w] = 1'b0; s_ack_i = 1'b0;
      tick(); tick();
      cyc[w] = 1'b1;
    end
    cyc = 2'b00;
    tick();
  endtask

  task automatic test_burst();
    bit got = 1'b0;
    do_reset();
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; cti[1] = 3'b010;
    for (int t = 0; t < 10 && !got; t++) begin
      #4;
      if (grant !== 2'b00) got = 1'b1; else tick();
    end
    checks++; if (!got || grant !== 2'b10) begin errors++; $display("FAIL burst_grant got %b exp 10", grant); end
    tick();
    for (int b = 1; b <= 4; b++) begin
      s_ack_i = 1'b1; s_dat_i = DW'(b); cti[1] = (b == 4) ? 3'b111 : 3'b010;
      if (b == 1) cyc[0] = 1'b1;
      #4;
      checks++; if (m1_ack_o !== 1'b1 || m1_dat_o !== DW'(b) || m0_ack_o !== 1'b0 || grant !== 2'b10) begin errors++; $display("FAIL burst_beat %0d got ack1=%b dat1=%h ack0=%b grant=%b", b, m1_ack_o, m1_dat_o, m0_ack_o, grant); end
      checks++; if (s_cti_o !== cti[1]) begin errors++; $display("FAIL burst_cti %0d got %b exp %b", b, s_cti_o, cti[1]); end
      tick();
    end
    cyc[1] = 1'b0; stb[1] = 1'b0; s_ack_i = 1'b0;
    for (int d = 0; d < 4; d++) begin
      #4;
      checks++; if (grant !== (d == 0 ? 2'b10 : (d == 3 ? 2'b01 : 2'b00))) begin errors++; $display("FAIL burst_handover d=%0d got %b", d, grant); end
      checks++; if (act_vec() !== exp_vec()) begin errors++; $display("FAIL burst_vec d=%0d got %h exp %h", d, act_vec(), exp_vec()); end
      tick();
    end
    cyc[0] = 1'b0;
    tick(); tick();
  endtask

  task automatic test_timeout();
    bit got = 1'b0;
    do_reset();
    cyc[0] = 1'b1; stb[0] = 1'b1;
    for (int t = 0; t < 10 && !got; t++) begin
      #4;
      if (grant !== 2'b00) got = 1'b1; else tick();
    end
    checks++; if (!got || m0_err_o !== 1'b0) begin errors++; $display("FAIL tmo_start got grant=%b err=%b exp 01 0", grant, m0_err_o); end
    tick();
    for (int k = 2; k <= 9; k++) begin
      if (k == 2) cyc[1] = 1'b1;
      #4;
      checks++; if (m0_err_o !== (k == 9) || s_cyc_o !== (k != 9) || s_stb_o !== (k != 9) || m1_err_o !== 1'b0) begin errors++; $display("FAIL tmo_cycle %0d got err=%b s_cyc=%b s_stb=%b", k, m0_err_o, s_cyc_o, s_stb_o); end
      tick();
    end
    cyc[0] = 1'b0; stb[0] = 1'b0;
    #4;
    checks++; if (tmo_flag !== 1'b1 || m0_err_o !== 1'b0) begin errors++; $display("FAIL tmo_flag got flag=%b err=%b exp 1 0", tmo_flag, m0_err_o); end
    tick();
    got = 1'b0;
    for (int t = 0; t < 10 && !got; t++) begin
      #4;
      if (grant !== 2'b00) got = 1'b1; else tick();
    end
    checks++; if (grant !== 2'b10 || tmo_flag !== 1'b1) begin errors++; $display("FAIL tmo_after got grant=%b flag=%b exp 10 1", grant, tmo_flag); end
    tick();
    cyc[1] = 1'b0;
    tick(); tick();
  endtask

  task automatic test_reset_mid_burst();
    bit got = 1'b0;
    do_reset();
    cyc[0] = 1'b1; stb[0] = 1'b1; cti[0] = 3'b010;
    for (int t = 0; t < 10 && !got; t++) begin
      #4;
      if (grant !== 2'b00) got = 1'b1; else tick();
    end
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL rst_burst_grant got %b exp 01", grant); end
    tick();
    s_ack_i = 1'b1; s_dat_i = 32'h11;
    #4; tick();
    s_dat_i = 32'h22; resetn = 1'b0;
    #4;
    checks++; if (m0_ack_o !== 1'b1) begin errors++; $display("FAIL rst_beat2_ack got %b exp 1", m0_ack_o); end
    tick();
    #4;
    checks++; if (grant !== 2'b00 || s_cyc_o !== 1'b0 || s_stb_o !== 1'b0 || s_addr_o !== '0 || s_dat_o !== '0 || s_cti_o !== '0 || m0_ack_o !== 1'b0) begin errors++; $display("FAIL rst_mid_burst got grant=%b cyc=%b stb=%b addr=%h ack=%b exp all 0", grant, s_cyc_o, s_stb_o, s_addr_o, m0_ack_o); end
    tick();
    resetn = 1'b1; cyc = 2'b10; stb = 2'b00; s_ack_i = 1'b0;
    got = 1'b0;
    for (int t = 0; t < 10 && !got; t++) begin
      #4;
      if (grant !== 2'b00) got = 1'b1; else tick();
    end
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL rst_then_m1 got %b exp 10", grant); end
    tick();
    cyc = 2'b00;
    tick(); tick();
  endtask

  task automatic test_random();
    int ack_pct;
    int bad = 0;
    do_reset();
    ack_pct = 50;
    for (int n = 0; n < 3000; n++) begin
      if (n % 500 == 0) ack_pct = (n / 500 % 3 == 0) ? 5 : ((n / 500 % 3 == 1) ? 50 : 90);
      resetn = ($urandom_range(0, 299) != 0);
      init   = ($urandom_range(0, 19) != 0);
      for (int unsigned i = 0; i < 2; i++) begin
        if ($urandom_range(0, 9) == 0) cyc[i] = ~cyc[i];
        if ($urandom_range(0, 9) == 0) stb[i] = ~stb[i];
        we[i] = $urandom; addr[i] = AW'($urandom); sel[i] = BW'($urandom);
        wdat[i] = $urandom; cti[i] = 3'($urandom);
      end
      s_ack_i = ($urandom_range(0, 99) < ack_pct);
      s_dat_i = $urandom;
      #4;
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        if (bad < 10) $display("FAIL random cycle %0d got %h exp %h", n, act_vec(), exp_vec());
        bad++;
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_burst();
    test_timeout();
    test_reset_mid_burst();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1, "simulation time limit");
  end

endmodule
